// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle sequencer for PC, IR, EPC and register-file write strobes.
//
// Each instruction is fetched, then decoded. It then either completes in DECODE (jump, eret),
// resolves in EXEC (branch, jr), writes back in WBACK (arithmetic), or traps through
// EXC_SAVE / EXC_VEC. Every retirement raises instr_done for one cycle and increments the
// 32-bit retired counter.
//
// Optional feature macro: PC_SEQ_CTRL_EXC_EN
//   defined   - op_illegal traps from DECODE, alu_overflow traps from EXEC, and the
//               EXC_SAVE / EXC_VEC states exist.
//   undefined - op_illegal and alu_overflow are ignored, epc_write and vec_sel stay 0,
//               and codes 4-5 behave like the unused codes 6-7.
//
// Ports:
//   clk          in   single clock; all state changes on its rising edge
//   reset        in   asynchronous, active-low reset
//   mem_ready    in   instruction memory read complete
//   op_beq       in   decoder flag: branch if equal
//   op_bne       in   decoder flag: branch if not equal
//   op_jump      in   decoder flag: direct jump
//   op_jr        in   decoder flag: jump register
//   op_eret      in   decoder flag: exception return
//   op_illegal   in   decoder flag: illegal instruction
//   zero         in   ALU zero flag (valid in EXEC)
//   alu_overflow in   ALU overflow flag (valid in EXEC)
//   pc_src       out  PC mux select: 00 ALUResult, 01 ALUOut, 10 ShiftLeft2Concat, 11 EPC
//   pc_write     out  PC load enable
//   ir_write     out  instruction register load enable
//   epc_write    out  EPC load enable
//   vec_sel      out  steers the exception vector onto ALUResult
//   reg_write    out  register file write enable
//   instr_done   out  one-cycle retirement pulse
//   state        out  current state code
//   retired      out  retired instruction count (wraps)

module pc_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic        op_beq,
    input  logic        op_bne,
    input  logic        op_jump,
    input  logic        op_jr,
    input  logic        op_eret,
    input  logic        op_illegal,
    input  logic        zero,
    input  logic        alu_overflow,
    output logic [1:0]  pc_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        epc_write,
    output logic        vec_sel,
    output logic        reg_write,
    output logic        instr_done,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExec    = 3'd2,
        StWback   = 3'd3,
        StExcSave = 3'd4,
        StExcVec  = 3'd5
    } state_e;

    localparam logic [1:0] PcAluResult = 2'b00;
    localparam logic [1:0] PcAluOut    = 2'b01;
    localparam logic [1:0] PcJumpAddr  = 2'b10;
    localparam logic [1:0] PcEpc       = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] retired_q;

`ifdef PC_SEQ_CTRL_EXC_EN
    logic illegal_trap;
    logic overflow_trap;
    assign illegal_trap  = op_illegal;
    assign overflow_trap = alu_overflow;
`else
    // Trap inputs are deliberately unused in this build.
    logic unused_trap_inputs;
    assign unused_trap_inputs = op_illegal ^ alu_overflow;
`endif

    // Outputs are combinational, but gated by reset so that an asserted reset
    // silences every strobe immediately, including FETCH's mem_ready-driven ones.
    always_comb begin
        state_d    = StFetch;
        pc_src     = PcAluResult;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        epc_write  = 1'b0;
        vec_sel    = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        if (reset) begin
            case (state_q)
                StFetch: begin
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                    state_d  = mem_ready ? StDecode : StFetch;
                end
                StDecode: begin
`ifdef PC_SEQ_CTRL_EXC_EN
                    if (illegal_trap) begin
                        state_d = StExcSave;
                    end else
`endif
                    if (op_jump) begin
                        pc_src     = PcJumpAddr;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end else if (op_eret) begin
                        pc_src     = PcEpc;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (op_beq) begin
                        pc_src     = PcAluOut;
                        pc_write   = zero;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end else if (op_bne) begin
                        pc_src     = PcAluOut;
                        pc_write   = ~zero;
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end else if (op_jr) begin
                        pc_src     = PcAluResult;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = StFetch;
`ifdef PC_SEQ_CTRL_EXC_EN
                    end else if (overflow_trap) begin
                        // Overflowed result must never reach the register file.
                        state_d = StExcSave;
`endif
                    end else begin
                        state_d = StWback;
                    end
                end
                StWback: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
`ifdef PC_SEQ_CTRL_EXC_EN
                StExcSave: begin
                    epc_write = 1'b1;
                    state_d   = StExcVec;
                end
                StExcVec: begin
                    vec_sel    = 1'b1;
                    pc_src     = PcAluResult;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
`endif
                // Unused codes recover to FETCH with no side effects.
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_ready;
    logic        op_beq, op_bne, op_jump, op_jr, op_eret, op_illegal;
    logic        zero, alu_overflow;
    logic [1:0]  pc_src;
    logic        pc_write, ir_write, epc_write, vec_sel, reg_write, instr_done;
    logic [2:0]  state;
    logic [31:0] retired;

    int          checks;
    int          errors;
    logic [31:0] exp_ret;

    pc_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mem_ready    (mem_ready),
        .op_beq       (op_beq),
        .op_bne       (op_bne),
        .op_jump      (op_jump),
        .op_jr        (op_jr),
        .op_eret      (op_eret),
        .op_illegal   (op_illegal),
        .zero         (zero),
        .alu_overflow (alu_overflow),
        .pc_src       (pc_src),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .epc_write    (epc_write),
        .vec_sel      (vec_sel),
        .reg_write    (reg_write),
        .instr_done   (instr_done),
        .state        (state),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        op_beq = 0; op_bne = 0; op_jump = 0; op_jr = 0; op_eret = 0; op_illegal = 0;
        zero = 0; alu_overflow = 0;
    endtask

    // From FETCH: one-cycle fetch, ends settled in DECODE.
    task automatic fetch_instr(input string name);
        mem_ready = 1;
        #1;
        checks++;
        if (state !== 3'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL %s_fetch state=%0d ir=%b pcw=%b expected 0 1 1",
                     name, state, ir_write, pc_write);
        end
        tick();
        mem_ready = 0;
        #1;
        checks++;
        if (state !== 3'd1 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_decode state=%0d pcw=%b expected 1 0", name, state, pc_write);
        end
    endtask

    // In EXEC: check resolution strobes, then step back to FETCH with one retirement.
    task automatic check_exec_resolve(input string name, input logic [1:0] e_src,
                                      input logic e_pcw);
        tick();
        checks++;
        if (state !== 3'd2 || pc_src !== e_src || pc_write !== e_pcw || instr_done !== 1'b1
            || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_exec state=%0d src=%b pcw=%b done=%b rw=%b expected 2 %b %b 1 0",
                     name, state, pc_src, pc_write, instr_done, reg_write, e_src, e_pcw);
        end
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        #1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL %s_ret state=%0d retired=%0d expected 0 %0d",
                     name, state, retired, exp_ret);
        end
    endtask

    task automatic test_reset();
        reset = 0; mem_ready = 1; clear_ops();
        tick();
        checks++;
        if (state !== 3'd0 || retired !== 32'd0 || ir_write !== 1'b0 || pc_write !== 1'b0
            || pc_src !== 2'b00 || instr_done !== 1'b0 || reg_write !== 1'b0
            || epc_write !== 1'b0 || vec_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset state=%0d ret=%0d ir=%b pcw=%b src=%b expected all zero",
                     state, retired, ir_write, pc_write, pc_src);
        end
        mem_ready = 0;
        reset = 1;
        exp_ret = 0;
    endtask

    task automatic test_fetch_wait();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 3'd0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait%0d state=%0d ir=%b pcw=%b expected 0 0 0",
                         i, state, ir_write, pc_write);
            end
            tick();
        end
        fetch_instr("fetch_wait");
        // Plain jump completes from DECODE.
        op_jump = 1;
        #1;
        checks++;
        if (pc_src !== 2'b10 || pc_write !== 1'b1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL jump_decode src=%b pcw=%b done=%b expected 10 1 1",
                     pc_src, pc_write, instr_done);
        end
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL jump_ret state=%0d retired=%0d expected 0 %0d",
                     state, retired, exp_ret);
        end
    endtask

    task automatic test_branch();
        fetch_instr("beq_t");  op_beq = 1; zero = 1; check_exec_resolve("beq_t", 2'b01, 1'b1);
        fetch_instr("beq_n");  op_beq = 1; zero = 0; check_exec_resolve("beq_n", 2'b01, 1'b0);
        fetch_instr("bne_t");  op_bne = 1; zero = 0; check_exec_resolve("bne_t", 2'b01, 1'b1);
        fetch_instr("bne_n");  op_bne = 1; zero = 1; check_exec_resolve("bne_n", 2'b01, 1'b0);
        // beq has priority over bne.
        fetch_instr("beq_pri"); op_beq = 1; op_bne = 1; zero = 1;
        check_exec_resolve("beq_pri", 2'b01, 1'b1);
        fetch_instr("jr");     op_jr = 1;               check_exec_resolve("jr", 2'b00, 1'b1);
    endtask

    task automatic test_jump_eret();
        fetch_instr("jmp_eret");
        op_jump = 1; op_eret = 1;
        #1;
        checks++;
        if (pc_src !== 2'b10 || pc_write !== 1'b1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL jump_pri src=%b pcw=%b done=%b expected 10 1 1",
                     pc_src, pc_write, instr_done);
        end
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL jump_pri_ret state=%0d retired=%0d expected 0 %0d",
                     state, retired, exp_ret);
        end
        fetch_instr("eret");
        op_eret = 1;
        #1;
        checks++;
        if (pc_src !== 2'b11 || pc_write !== 1'b1 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL eret src=%b pcw=%b done=%b expected 11 1 1",
                     pc_src, pc_write, instr_done);
        end
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL eret_ret state=%0d retired=%0d expected 0 %0d",
                     state, retired, exp_ret);
        end
    endtask

    // Arithmetic: DECODE -> EXEC -> WBACK. Ends settled in WBACK when stop_in_wback is set.
    task automatic run_arith(input string name, input logic ovf, input logic stop_in_wback);
        fetch_instr(name);
        alu_overflow = ovf;
        tick();
        checks++;
        if (state !== 3'd2 || pc_write !== 1'b0 || instr_done !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_exec state=%0d pcw=%b done=%b rw=%b expected 2 0 0 0",
                     name, state, pc_write, instr_done, reg_write);
        end
        tick();
        checks++;
        if (state !== 3'd3 || reg_write !== 1'b1 || instr_done !== 1'b1 || pc_write !== 1'b0
            || epc_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_wback state=%0d rw=%b done=%b pcw=%b epc=%b expected 3 1 1 0 0",
                     name, state, reg_write, instr_done, pc_write, epc_write);
        end
        if (!stop_in_wback) begin
            tick();
            clear_ops();
            exp_ret = exp_ret + 1;
            checks++;
            if (state !== 3'd0 || retired !== exp_ret) begin
                errors++;
                $display("FAIL %s_ret state=%0d retired=%0d expected 0 %0d",
                         name, state, retired, exp_ret);
            end
        end
    endtask

    task automatic test_arith();
        run_arith("arith", 1'b0, 1'b0);
    endtask

`ifdef PC_SEQ_CTRL_EXC_EN
    task automatic test_exception();
        fetch_instr("ovf");
        alu_overflow = 1;
        tick();
        checks++;
        if (state !== 3'd2 || reg_write !== 1'b0 || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_exec state=%0d rw=%b done=%b expected 2 0 0",
                     state, reg_write, instr_done);
        end
        tick();
        checks++;
        if (state !== 3'd4 || epc_write !== 1'b1 || reg_write !== 1'b0 || pc_write !== 1'b0
            || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_save state=%0d epc=%b rw=%b pcw=%b done=%b expected 4 1 0 0 0",
                     state, epc_write, reg_write, pc_write, instr_done);
        end
        tick();
        checks++;
        if (state !== 3'd5 || vec_sel !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00
            || instr_done !== 1'b1 || epc_write !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL ovf_vec state=%0d vec=%b pcw=%b src=%b done=%b epc=%b rw=%b",
                     state, vec_sel, pc_write, pc_src, instr_done, epc_write, reg_write);
        end
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL ovf_ret state=%0d retired=%0d expected 0 %0d",
                     state, retired, exp_ret);
        end
        // Illegal outranks jump in DECODE.
        fetch_instr("ill");
        op_illegal = 1; op_jump = 1;
        #1;
        checks++;
        if (pc_write !== 1'b0 || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL ill_decode pcw=%b done=%b expected 0 0", pc_write, instr_done);
        end
        tick();
        checks++;
        if (state !== 3'd4 || epc_write !== 1'b1) begin
            errors++;
            $display("FAIL ill_save state=%0d epc=%b expected 4 1", state, epc_write);
        end
        tick();
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL ill_ret state=%0d retired=%0d expected 0 %0d",
                     state, retired, exp_ret);
        end
    endtask
`else
    task automatic test_exception();
        // Overflow is ignored: normal writeback.
        run_arith("ovf_ign", 1'b1, 1'b0);
        // Illegal is ignored: jump is taken.
        fetch_instr("ill_ign");
        op_illegal = 1; op_jump = 1;
        #1;
        checks++;
        if (pc_src !== 2'b10 || pc_write !== 1'b1 || instr_done !== 1'b1 || epc_write !== 1'b0) begin
            errors++;
            $display("FAIL ill_ign src=%b pcw=%b done=%b epc=%b expected 10 1 1 0",
                     pc_src, pc_write, instr_done, epc_write);
        end
        tick();
        clear_ops();
        exp_ret = exp_ret + 1;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret || vec_sel !== 1'b0) begin
            errors++;
            $display("FAIL ill_ign_ret state=%0d retired=%0d vec=%b expected 0 %0d 0",
                     state, retired, vec_sel, exp_ret);
        end
    endtask
`endif

    task automatic test_wrap();
        mem_ready = 0;
        force dut.retired_q = 32'hFFFF_FFFF;
        tick();
        release dut.retired_q;
        tick();
        checks++;
        if (retired !== 32'hFFFF_FFFF || state !== 3'd0) begin
            errors++;
            $display("FAIL wrap_preload retired=%h state=%0d expected ffffffff 0", retired, state);
        end
        fetch_instr("wrap");
        op_jump = 1;
        tick();
        clear_ops();
        exp_ret = 32'd0;
        checks++;
        if (retired !== 32'h0000_0000 || state !== 3'd0) begin
            errors++;
            $display("FAIL wrap retired=%h state=%0d expected 00000000 0", retired, state);
        end
    endtask

    task automatic test_reset_mid();
        run_arith("rst_mid", 1'b0, 1'b1);
        // Mid-cycle in WBACK: reset must act without waiting for an edge.
        reset = 0;
        #1;
        checks++;
        if (reg_write !== 1'b0 || instr_done !== 1'b0 || state !== 3'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_async rw=%b done=%b state=%0d retired=%0d expected 0 0 0 0",
                     reg_write, instr_done, state, retired);
        end
        mem_ready = 1;
        tick();
        checks++;
        if (state !== 3'd0 || ir_write !== 1'b0 || pc_write !== 1'b0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_hold state=%0d ir=%b pcw=%b retired=%0d expected 0 0 0 0",
                     state, ir_write, pc_write, retired);
        end
        reset = 1;
        #1;
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_release ir=%b pcw=%b expected 1 1", ir_write, pc_write);
        end
        tick();
        mem_ready = 0;
        checks++;
        if (state !== 3'd1 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_first state=%0d retired=%0d expected 1 0", state, retired);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_ret = 0;
        test_reset();
        test_fetch_wait();
        test_branch();
        test_jump_eret();
        test_arith();
        test_exception();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 The block SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
- mem_ready  in  1  instruction memory read complete.
- op_beq, op_bne, op_jump, op_jr, op_eret, op_illegal  in  1 each  decoder class flags, valid from DECODE until instruction end.
- zero  in  1  ALU zero flag, valid in EXEC.
- alu_overflow  in  1  ALU overflow, valid in EXEC.
- pc_src  out  2  PC source mux select: 00 ALUResult, 01 ALUOut, 10 ShiftLeft2Concat, 11 EPC.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction register load enable.
- epc_write  out  1  EPC load enable.
- vec_sel  out  1  steers the exception vector onto ALUResult.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse at instruction retirement.
- state  out  3  current FSM state code.
- retired  out  32  count of retired instructions.

Function
REQ-002 States and codes SHALL be: FETCH=0, DECODE=1, EXEC=2, WBACK=3, EXC_SAVE=4, EXC_VEC=5; codes 6-7 SHALL return to FETCH on the next edge.
REQ-003 pc_write, ir_write, epc_write, vec_sel, reg_write and instr_done SHALL be combinational functions of state and inputs; each is 0 wherever a state does not assert it; pc_src defaults to 00.
REQ-004 FETCH: ir_write=pc_write=mem_ready, pc_src=00 (PC+4); on mem_ready go DECODE, otherwise remain in FETCH with no side effects.
REQ-005 DECODE priority, highest first: op_illegal -> EXC_SAVE; op_jump -> pc_src=10, pc_write=1, instr_done=1, -> FETCH; op_eret -> pc_src=11, pc_write=1, instr_done=1, -> FETCH; otherwise -> EXEC.
REQ-006 EXEC priority, highest first: op_beq -> pc_src=01, pc_write=zero; op_bne -> pc_src=01, pc_write=~zero; op_jr -> pc_src=00, pc_write=1; each of these asserts instr_done and goes to FETCH.
REQ-007 EXEC with no branch/jr flag: alu_overflow=1 -> EXC_SAVE with no reg_write; otherwise -> WBACK.
REQ-008 WBACK SHALL assert reg_write=1 and instr_done=1, then go to FETCH.
REQ-009 EXC_SAVE SHALL assert epc_write=1 for exactly one cycle, then go to EXC_VEC.
REQ-010 EXC_VEC SHALL assert vec_sel=1, pc_src=00, pc_write=1 and instr_done=1, then go to FETCH.
REQ-011 retired SHALL increment by 1 on every edge where instr_done=1, wrapping from 0xFFFFFFFF to 0.
REQ-012 Minimum latencies: jump/eret 2 cycles; branch/jr 3; arithmetic 4; exception from DECODE 4; each is extended by FETCH wait cycles.

Reset
REQ-013 While reset=0: state=FETCH, retired=0, and all single-bit outputs and pc_src SHALL be forced to 0, regardless of mem_ready.
REQ-014 Reset asserted mid-instruction SHALL abandon the instruction without a retirement count; the first edge after release evaluates FETCH.

Configuration
REQ-015 Macro PC_SEQ_CTRL_EXC_EN defined: REQ-005 op_illegal path, REQ-007 overflow path and EXC_SAVE/EXC_VEC states present.
REQ-016 PC_SEQ_CTRL_EXC_EN undefined: op_illegal and alu_overflow SHALL be ignored; epc_write and vec_sel tied to 0; codes 4-5 SHALL behave as unused codes (-> FETCH); op_eret remains supported.

Verification
REQ-017 Release reset, mem_ready=0 for 3 cycles then 1 -> state stays 0 for 3 cycles; pc_write=ir_write=1 for one cycle; state=1 next.
REQ-018 op_beq=1, zero=1 -> EXEC cycle pc_src=01, pc_write=1, instr_done=1; repeat with zero=0 -> pc_write=0, instr_done=1, retired=2.
REQ-019 op_jump=1 and op_eret=1 together in DECODE -> pc_src=10, pc_write=1, state returns to 0, retired +1.
REQ-020 Arithmetic instruction with alu_overflow=1 (EXC_EN defined) -> reg_write never 1; states 2,4,5; epc_write=1 in state 4; vec_sel=1, pc_write=1 in state 5; retired +1.
REQ-021 Preload retired to 0xFFFFFFFF via 2^32-1 retirements (or force), retire one -> retired=0x00000000.
REQ-022 Assert reset=0 in state 3 asynchronously -> reg_write and instr_done drop in the same cycle, state=0, retired=0.
